// File: rtl/syscall_input_ctrl_if.sv
// Request/response bundle between the processor syscall path and the
// syscall input controller: the request handshake, the input byte stream
// and the result/status returned to the processor.
interface syscall_input_ctrl_if;
    logic        start;
    logic [31:0] code;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd;

    // Processor / stimulus side
    modport master (
        output start, code, in_valid, in_data,
        input  in_ready, busy, done, err, rd
    );

    // Controller side
    modport slave (
        input  start, code, in_valid, in_data,
        output in_ready, busy, done, err, rd
    );
endinterface

// File: rtl/syscall_input_ctrl.sv
// Syscall input controller: services "read" syscalls by pulling ASCII bytes
// from an input byte stream and returning a parsed 32-bit value on rd.
//   code 9  : read signed decimal integer
//   code 10 : read unsigned decimal integer
//   code 11 : read up to four characters, packed big-endian
// Optional build macro SYSCALL_INPUT_TIMEOUT_EN adds an idle-input timeout
// (parameter TIMEOUT); without it the block waits indefinitely for bytes.
module syscall_input_ctrl #(
    parameter int MAX_DIGITS = 10
`ifdef SYSCALL_INPUT_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input logic                 clk,
    input logic                 reset,
    syscall_input_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        NUM,
        STR,
        DONE
    } state_t;

    // Digit counter must be able to hold MAX_DIGITS itself
    localparam int CW = $clog2(MAX_DIGITS + 2);

    state_t          state;
    logic [31:0]     acc;
    logic [31:0]     rd_q;
    logic            err_q;
    logic            neg;
    logic            is_signed;
    logic [CW-1:0]   digit_cnt;
    logic [1:0]      byte_idx;

`ifdef SYSCALL_INPUT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   timer;
`endif

    logic            active;
    logic            xfer;
    logic            is_digit;
    logic            is_ws;
    logic [31:0]     digit_val;

    // Handshake outputs are pure decodes of the registered state, so they
    // carry no combinational path from the inputs.
    assign active       = (state == SKIP) || (state == NUM) || (state == STR);
    assign bus.in_ready = active;
    assign bus.busy     = active;
    assign bus.done     = (state == DONE);
    assign bus.rd       = rd_q;
    assign bus.err      = err_q;

    assign xfer      = bus.in_valid && active;
    assign is_digit  = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    assign is_ws     = (bus.in_data == 8'h20) || (bus.in_data == 8'h0A) ||
                       (bus.in_data == 8'h0D);
    assign digit_val = {24'd0, bus.in_data - 8'h30};

    // Request sequencing, number parsing and string packing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            neg       <= 1'b0;
            is_signed <= 1'b0;
            digit_cnt <= '0;
            byte_idx  <= '0;
`ifdef SYSCALL_INPUT_TIMEOUT_EN
            timer     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_q <= 1'b0;
                        if (bus.code == 32'd9 || bus.code == 32'd10) begin
                            is_signed <= (bus.code == 32'd9);
                            acc       <= '0;
                            neg       <= 1'b0;
                            digit_cnt <= '0;
                            state     <= SKIP;
                        end else if (bus.code == 32'd11) begin
                            rd_q     <= '0;
                            byte_idx <= '0;
                            state    <= STR;
                        end else begin
                            rd_q  <= '0;
                            err_q <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                SKIP: begin
                    if (xfer) begin
                        if (is_ws) begin
                            state <= SKIP;
                        end else if (bus.in_data == 8'h2D && is_signed) begin
                            neg   <= 1'b1;
                            state <= NUM;
                        end else if (is_digit) begin
                            acc       <= digit_val;
                            digit_cnt <= CW'(1);
                            state     <= NUM;
                        end else begin
                            rd_q  <= '0;
                            err_q <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                NUM: begin
                    if (xfer) begin
                        if (is_digit) begin
                            if (digit_cnt == CW'(MAX_DIGITS)) begin
                                rd_q  <= '0;
                                err_q <= 1'b1;
                                state <= DONE;
                            end else begin
                                acc       <= acc * 32'd10 + digit_val;
                                digit_cnt <= digit_cnt + 1'b1;
                            end
                        end else if (is_ws) begin
                            if (digit_cnt == '0) begin
                                rd_q  <= '0;
                                err_q <= 1'b1;
                            end else begin
                                rd_q <= neg ? (32'd0 - acc) : acc;
                            end
                            state <= DONE;
                        end else begin
                            rd_q  <= '0;
                            err_q <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                STR: begin
                    if (xfer) begin
                        if (bus.in_data == 8'h0A) begin
                            state <= DONE;
                        end else begin
                            case (byte_idx)
                                2'd0:    rd_q[31:24] <= bus.in_data;
                                2'd1:    rd_q[23:16] <= bus.in_data;
                                2'd2:    rd_q[15:8]  <= bus.in_data;
                                default: rd_q[7:0]   <= bus.in_data;
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                state <= DONE;
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef SYSCALL_INPUT_TIMEOUT_EN
            if (state == IDLE || xfer) begin
                timer <= '0;
            end else if (active && !bus.in_valid) begin
                if (timer == TW'(TIMEOUT - 1)) begin
                    rd_q  <= '0;
                    err_q <= 1'b1;
                    state <= DONE;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_syscall_input_ctrl.sv
// Directed testbench for syscall_input_ctrl: requests are issued in one
// linear sequence, expected results are queued at request time and checked
// against the DUT when done is raised.
module tb_syscall_input_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    syscall_input_ctrl_if bus ();

`ifdef SYSCALL_INPUT_TIMEOUT_EN
    syscall_input_ctrl #(.MAX_DIGITS(10), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    syscall_input_ctrl #(.MAX_DIGITS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic checkValue(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start at a falling edge; optionally queue the result
    task automatic applyStimulus(input logic [31:0] code, input logic [31:0] exp_rd,
                                 input logic exp_err, input string tag,
                                 input bit expect_done);
        exp_t e;
        e.rd  = exp_rd;
        e.err = exp_err;
        e.tag = tag;
        if (expect_done) sb.push_back(e);
        bus.start = 1'b1;
        bus.code  = code;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offer one byte and hold it until the rising edge that accepts it
    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) checkValue("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
    endtask

    // Wait for done (expected after exactly 'lat' extra cycles), then
    // compare against the oldest queued expectation
    task automatic checkOutput(input int lat);
        int   waited = 0;
        exp_t e;
        while (bus.done !== 1'b1 && waited < lat + 20) begin
            @(negedge clk);
            waited++;
        end
        checkValue("done_latency", 32'(waited), 32'(lat));
        checkValue("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkValue({e.tag, "_rd"}, bus.rd, e.rd);
            checkValue({e.tag, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
        end
        checkValue("busy_at_done", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        checkValue("done_pulse_end", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.code     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
        checkValue("reset_rd", bus.rd, 32'd0);
        checkValue("reset_flags",
                   {27'd0, bus.err, bus.done, bus.busy, bus.in_ready, 1'b0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Signed read with leading whitespace
        applyStimulus(32'd9, 32'hFFFF_FF85, 1'b0, "signed_neg123", 1'b1);
        sendStr(" -123\n");
        checkOutput(0);

        // Unsigned read wrapping mod 2^32
        applyStimulus(32'd10, 32'd1, 1'b0, "unsigned_wrap", 1'b1);
        sendStr("4294967297 ");
        checkOutput(0);

        // Minus sign on unsigned read; following '5' must be left unconsumed
        applyStimulus(32'd10, 32'd0, 1'b1, "unsigned_minus", 1'b1);
        sendByte(8'h2D);
        checkOutput(0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h35;
        #1;
        checkValue("five_not_taken", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;

        // String reads: newline-terminated and full four characters
        applyStimulus(32'd11, 32'h4869_2100, 1'b0, "str_hi", 1'b1);
        sendStr("Hi!\n");
        checkOutput(0);
        applyStimulus(32'd11, 32'h4142_4344, 1'b0, "str_abcd", 1'b1);
        sendStr("ABCD");
        checkOutput(0);

        // Error cases
        applyStimulus(32'd7, 32'd0, 1'b1, "bad_code", 1'b1);
        checkOutput(0);
        applyStimulus(32'd9, 32'd0, 1'b1, "bad_char", 1'b1);
        sendStr("12a");
        checkOutput(0);
        applyStimulus(32'd9, 32'd0, 1'b1, "too_many_digits", 1'b1);
        sendStr("12345678901");
        checkOutput(0);

        // Handshake stall with a stray start and junk data while idle-valid
        applyStimulus(32'd9, 32'd42, 1'b0, "stall_42", 1'b1);
        sendByte(8'h34);
        bus.in_data = 8'h39;
        bus.start   = 1'b1;
        bus.code    = 32'd7;
        checkValue("stall_busy_0", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        sendByte(8'h32);
        bus.in_data = 8'h39;
        checkValue("stall_busy_1", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        sendByte(8'h0A);
        checkOutput(0);

        // Reset in the middle of a request
        applyStimulus(32'd9, 32'd0, 1'b0, "reset_mid", 1'b0);
        sendStr("12");
        reset = 1'b1;
        #1;
        checkValue("midreset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkValue("midreset_busy", {31'd0, bus.busy}, 32'd0);
        checkValue("midreset_rd", bus.rd, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkValue("midreset_no_done", {31'd0, bus.done}, 32'd0);
        applyStimulus(32'd9, 32'd7, 1'b0, "after_reset", 1'b1);
        sendStr("7\n");
        checkOutput(0);

`ifdef SYSCALL_INPUT_TIMEOUT_EN
        // No input at all: abort after TIMEOUT idle cycles
        applyStimulus(32'd9, 32'd0, 1'b1, "timeout", 1'b1);
        checkOutput(16);
`endif

        checkValue("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/syscall_input_ctrl.md
Name: syscall_input_ctrl

Overview:
- Input-direction counterpart to the syscall display path: services "read" syscalls by pulling ASCII bytes from an input byte stream (keyboard/stdin model) and returning a parsed 32-bit value on rd.
- Sits beside the syscall display controller on the processor's syscall path.
- The processor raises start, stalls on busy, and captures rd on done.

Parameters:
- MAX_DIGITS, 10, maximum decimal digits accepted before error.
- TIMEOUT, 1024, idle cycles waiting for a byte before abort (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle syscall read request, sampled only in IDLE.
- code  input  32  syscall code: 9 = read signed int, 10 = read unsigned int, 11 = read 4-char string.
- in_valid  input  1  input byte available.
- in_data  input  8  ASCII input byte.
- in_ready  output  1  block accepts in_data this cycle.
- busy  output  1  request in progress; processor stalls.
- done  output  1  one-cycle completion pulse.
- err  output  1  error status of last request, held until next start.
- rd  output  32  result, held until next accepted start.

Behaviour:
- Reset: all of the following are 0: rd, err, done, busy, in_ready, accumulator, digit count, neg flag, byte index; state = IDLE. Reset acts immediately at any time, including mid-request; the partial request is discarded and no done pulse is issued.
- Byte transfer: a byte transfers only when in_valid && in_ready on a rising edge. Exactly one byte per cycle at most.
- in_ready is 1 only in states SKIP, NUM and STR.
- States: IDLE, SKIP, NUM, STR, DONE.
- IDLE:
  - start with code 9 or 10 -> SKIP. Clear accumulator, neg, digit count and err; busy = 1.
  - start with code 11 -> STR. Clear rd and byte index; busy = 1.
  - start with any other code -> DONE with rd = 0, err = 1.
  - start while busy is impossible (start is sampled only in IDLE); it is ignored.
- SKIP (leading whitespace):
  - Bytes 0x20, 0x0A and 0x0D are discarded.
  - '-' (0x2D) with code 9: set neg, go to NUM.
  - '-' with code 10: err = 1, go to DONE.
  - Digit 0x30-0x39: acc = d, count = 1, go to NUM.
  - Any other byte: err = 1, go to DONE.
- NUM:
  - Digit: acc = acc*10 + (byte - 0x30), truncated mod 2^32; count++.
  - If count would exceed MAX_DIGITS: err = 1, go to DONE.
  - Terminator (0x20, 0x0A, 0x0D):
    - If count == 0 (a lone '-'): err = 1.
    - Otherwise rd = neg ? -acc : acc (two's complement).
    - Go to DONE.
  - Other byte: err = 1, go to DONE.
  - Whenever err = 1 the request ends with rd = 0.
- STR:
  - Bytes pack big-endian: byte index 0 goes to rd[31:24], index 3 to rd[7:0].
  - After the 4th byte: go to DONE.
  - 0x0A before 4 bytes: the 0x0A is consumed but not stored; remaining bytes stay 0x00; go to DONE.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE.
- Latency:
  - Numeric and string requests: done is high the cycle after the terminating (or 4th) byte transfer.
  - Invalid code: done is high the cycle after start.

Optional Feature:
- Macro: SYSCALL_INPUT_TIMEOUT_EN.
- Defined:
  - A counter is cleared on each byte transfer and on entry to SKIP/STR.
  - It increments each cycle in SKIP/NUM/STR while !in_valid.
  - On reaching TIMEOUT: rd = 0, err = 1, go to DONE.
- Undefined: no counter; the block waits indefinitely for input.

Test Plan:
- Signed read: start, code = 9; bytes " -123\n" with in_valid held high -> done one cycle after the '\n' transfer; rd = 0xFFFFFF85; err = 0.
- Unsigned read with wrap: code = 10; bytes "4294967297 " -> rd = 0x00000001; err = 0. Then code = 10 with bytes "-5" -> err = 1, rd = 0, and the '5' is not consumed.
- String read: code = 11; bytes "Hi!\n" -> rd = 0x48692100. Then code = 11 with "ABCD" -> rd = 0x41424344, done without waiting for a terminator.
- Errors:
  - code = 7 -> done next cycle, err = 1, rd = 0.
  - code = 9 with "12a" -> err = 1 on the 'a' byte.
  - code = 9 with 11 digits -> err = 1.
- Handshake stall: in_valid toggles every other cycle during "42\n" -> only handshaked bytes count; rd = 42; busy stays high throughout; a start pulse issued mid-request is ignored.
- Reset mid-request: assert reset after "12" -> immediately in_ready = 0, busy = 0, rd = 0. After release, a new request with "7\n" -> rd = 7. With SYSCALL_INPUT_TIMEOUT_EN and TIMEOUT = 16: no input for 16 cycles -> done, err = 1.
